// File: rtl/jtroadf_objarb_pkg.sv
// jtroadf_objarb_pkg
//   Shared types and constants for the object RAM arbiter.
//   state_t  : access sequencer states (IDLE, ACC, LAT)
//   SEL_*    : which requester owns the access in flight
//   STATS_W  : width of the optional scanner wait counter
//              (present only with JTROADF_OBJARB_STATS_EN defined)
package jtroadf_objarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        LAT  = 2'd2
    } state_t;

    localparam logic SEL_CPU  = 1'b0;
    localparam logic SEL_SCAN = 1'b1;

    localparam int STATS_W = 16;

endpackage

// File: rtl/jtroadf_objram_arb.sv
// jtroadf_objram_arb
//   Arbiter and bank controller for the double-buffered object RAM. One
//   single-port 2 x 2^AW RAM is shared by the CPU (bank obj_frame) and the
//   object line scanner (bank ~obj_frame). Each access takes 3 clks:
//   grant in IDLE, address/write in ACC, read data captured in LAT.
//
//   Ports
//     clk, rst              system clock, synchronous active-high reset
//     cpu_cen/cs/rnw/addr/wdata  CPU bus strobe and request
//     cpu_rdata             last CPU read result
//     frame_tgl             one-clk bank swap request
//     obj_frame             current CPU bank
//     scan_req/addr         scanner request (held until scan_ack)
//     scan_ack              one-clk grant pulse
//     scan_data/scan_dv     scanner read data and valid pulse
//     ram_addr/we/din       registered RAM controls, ram_addr = {bank, addr}
//     ram_dout              RAM read data, one clk after ram_addr
//     scan_wait_cnt         optional, only with JTROADF_OBJARB_STATS_EN:
//                           saturating count of clks the scanner waited,
//                           cleared on reset and on each bank swap
//
//   state | meaning
//   IDLE  | apply pending swap, arbitrate (CPU before scanner)
//   ACC   | RAM address presented, write strobe ends
//   LAT   | ram_dout valid, capture for the owning requester
module jtroadf_objram_arb
    import jtroadf_objarb_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic          cpu_cs,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          frame_tgl,
    output logic          obj_frame,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic          scan_ack,
    output logic [DW-1:0] scan_data,
    output logic          scan_dv,
    output logic [AW:0]   ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
`ifdef JTROADF_OBJARB_STATS_EN
    ,
    output logic [STATS_W-1:0] scan_wait_cnt
`endif
);

    state_t          state;
    logic            sel;
    logic            sel_rnw;

    logic            cpu_pend;
    logic            cpu_rnw_q;
    logic [AW-1:0]   cpu_addr_q;
    logic [DW-1:0]   cpu_wdata_q;
    logic            swap_pend;

    logic            cpu_stb;
    logic            cpu_req;
    logic            cpu_rnw_e;
    logic [AW-1:0]   cpu_addr_e;
    logic [DW-1:0]   cpu_wdata_e;
    logic            swap_eff;
    logic            swap_apply;
    logic            frame_use;

    // A live strobe is granted in the same clk it arrives and takes
    // precedence over an older latched request (latest wins).
    assign cpu_stb     = cpu_cs & cpu_cen;
    assign cpu_req     = cpu_stb | cpu_pend;
    assign cpu_rnw_e   = cpu_stb ? cpu_rnw   : cpu_rnw_q;
    assign cpu_addr_e  = cpu_stb ? cpu_addr  : cpu_addr_q;
    assign cpu_wdata_e = cpu_stb ? cpu_wdata : cpu_wdata_q;

    // A toggle arriving in the same clk counts, so a swap coincident with a
    // CPU strobe lands before that access; two toggles cancel.
    assign swap_eff   = swap_pend ^ frame_tgl;
    assign swap_apply = (state == IDLE) & swap_eff;
    assign frame_use  = obj_frame ^ swap_apply;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_pend    <= 1'b0;
            cpu_rnw_q   <= 1'b1;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
        end else begin
            if (cpu_stb) begin
                cpu_rnw_q   <= cpu_rnw;
                cpu_addr_q  <= cpu_addr;
                cpu_wdata_q <= cpu_wdata;
            end
            if (state == IDLE && cpu_req)
                cpu_pend <= 1'b0;
            else if (cpu_stb)
                cpu_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= SEL_CPU;
            sel_rnw   <= 1'b1;
            obj_frame <= 1'b0;
            swap_pend <= 1'b0;
            cpu_rdata <= '0;
            scan_data <= '0;
            scan_ack  <= 1'b0;
            scan_dv   <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_din   <= '0;
        end else begin
            scan_ack <= 1'b0;
            scan_dv  <= 1'b0;
            if (swap_apply) begin
                obj_frame <= ~obj_frame;
                swap_pend <= 1'b0;
            end else begin
                swap_pend <= swap_eff;
            end
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state    <= ACC;
                        sel      <= SEL_CPU;
                        sel_rnw  <= cpu_rnw_e;
                        ram_addr <= {frame_use, cpu_addr_e};
                        ram_we   <= ~cpu_rnw_e;
                        ram_din  <= cpu_wdata_e;
                    end else if (scan_req) begin
                        state    <= ACC;
                        sel      <= SEL_SCAN;
                        sel_rnw  <= 1'b1;
                        ram_addr <= {~frame_use, scan_addr};
                        ram_we   <= 1'b0;
                        scan_ack <= 1'b1;
                    end
                end
                ACC: begin
                    ram_we <= 1'b0;
                    state  <= LAT;
                end
                LAT: begin
                    if (sel == SEL_SCAN) begin
                        scan_data <= ram_dout;
                        scan_dv   <= 1'b1;
                    end else if (sel_rnw) begin
                        cpu_rdata <= ram_dout;
                    end
                    state <= IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef JTROADF_OBJARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || swap_apply)
            scan_wait_cnt <= '0;
        else if (scan_req && !scan_ack && scan_wait_cnt != {STATS_W{1'b1}})
            scan_wait_cnt <= scan_wait_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_jtroadf_objram_arb.sv
// tb_jtroadf_objram_arb
//   Directed bench for jtroadf_objram_arb with a behavioural synchronous RAM.
//   Checks the scan_wait_cnt port when JTROADF_OBJARB_STATS_EN is defined.
module tb_jtroadf_objram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cen, cpu_cs, cpu_rnw;
    logic [9:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        frame_tgl;
    logic        obj_frame;
    logic        scan_req;
    logic [9:0]  scan_addr;
    logic        scan_ack;
    logic [7:0]  scan_data;
    logic        scan_dv;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
`ifdef JTROADF_OBJARB_STATS_EN
    logic [15:0] scan_wait_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtroadf_objram_arb #(.AW(10), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_cen   (cpu_cen),
        .cpu_cs    (cpu_cs),
        .cpu_rnw   (cpu_rnw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .frame_tgl (frame_tgl),
        .obj_frame (obj_frame),
        .scan_req  (scan_req),
        .scan_addr (scan_addr),
        .scan_ack  (scan_ack),
        .scan_data (scan_data),
        .scan_dv   (scan_dv),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef JTROADF_OBJARB_STATS_EN
        ,
        .scan_wait_cnt (scan_wait_cnt)
`endif
    );

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [7:0] pat(input logic [10:0] a);
        return a[7:0] ^ {5'b0, a[10:8]};
    endfunction

    logic [7:0] mem [0:2047];
    bit         wr  [0:2047];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wr[ram_addr]  <= 1'b1;
        end
        ram_dout <= wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_strobe(input logic rnw, input logic [9:0] a, input logic [7:0] d);
        cpu_cen   = 1'b1;
        cpu_cs    = 1'b1;
        cpu_rnw   = rnw;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    // Continuous-scan bookkeeping
    int         last_ack;
    int         n_ack, n_cpu, n_dv;
    logic [9:0] sa;
    logic [7:0] expq [$];

    task automatic obs_cycle(input int c);
        if (scan_ack) begin
            n_ack++;
            if (last_ack >= 0)
                chk("ack_spacing_ge3", 32'(c - last_ack >= 3), 32'd1);
            expq.push_back(pat({1'b0, sa}));
            sa        = sa + 10'd1;
            scan_addr = sa;
            last_ack  = c;
        end
        if (ram_we)
            n_cpu++;
        if (scan_dv) begin
            n_dv++;
            chk("dv_has_pending_ack", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0)
                chk("cont_scan_data", scan_data, expq.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_cen = 1'b0; cpu_cs = 1'b0; cpu_rnw = 1'b1;
        cpu_addr = '0; cpu_wdata = '0;
        frame_tgl = 1'b0; scan_req = 1'b0; scan_addr = '0;

        // Reset values
        tick(); tick(); tick();
        chk("rst_obj_frame", obj_frame, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_scan_ack", scan_ack, 0);
        chk("rst_scan_dv", scan_dv, 0);
        rst = 1'b0;
        tick();

        // CPU write 0x05 <- 0xA5, bank 0
        cpu_strobe(1'b0, 10'h005, 8'hA5);
        tick();
        cpu_cs = 1'b0;
        chk("wr_ram_addr", ram_addr, 11'h005);
        chk("wr_ram_we_on", ram_we, 1);
        chk("wr_ram_din", ram_din, 8'hA5);
        tick();
        chk("wr_ram_we_1clk", ram_we, 0);
        tick();

        // CPU read 0x05 -> 0xA5 two clks after grant
        cpu_strobe(1'b1, 10'h005, 8'h00);
        tick();
        cpu_cs = 1'b0;
        chk("rd_ram_we", ram_we, 0);
        tick();
        chk("rd_rdata_early", cpu_rdata, 0);
        tick();
        chk("rd_rdata", cpu_rdata, 8'hA5);

        // Single swap
        frame_tgl = 1'b1;
        tick();
        frame_tgl = 1'b0;
        chk("swap_obj_frame", obj_frame, 1);

        // Scanner now reads bank 0
        scan_req = 1'b1; scan_addr = 10'h005;
        tick();
        chk("scan_ack", scan_ack, 1);
        chk("scan_ram_addr", ram_addr, 11'h005);
        scan_req = 1'b0;
        tick();
        chk("scan_ack_1clk", scan_ack, 0);
        tick();
        chk("scan_dv", scan_dv, 1);
        chk("scan_data", scan_data, 8'hA5);
        tick();
        chk("scan_dv_1clk", scan_dv, 0);

        // CPU write lands in bank 1
        cpu_strobe(1'b0, 10'h005, 8'h3C);
        tick();
        cpu_cs = 1'b0;
        chk("wr_bank1_addr", ram_addr, 11'h405);
        chk("wr_bank1_we", ram_we, 1);
        tick(); tick();

        // Simultaneous CPU strobe and scan_req: CPU first
        cpu_strobe(1'b1, 10'h005, 8'h00);
        scan_req = 1'b1; scan_addr = 10'h005;
        tick();
        cpu_cs = 1'b0;
        chk("sim_cpu_first_addr", ram_addr, 11'h405);
        chk("sim_no_ack_0", scan_ack, 0);
        tick(); tick();
        chk("sim_cpu_rdata", cpu_rdata, 8'h3C);
        chk("sim_no_ack_2", scan_ack, 0);
        tick();
        chk("sim_ack_at_3", scan_ack, 1);
        chk("sim_scan_addr", ram_addr, 11'h005);
        scan_req = 1'b0;
        tick();
        chk("sim_dv_not_early", scan_dv, 0);
        tick();
        chk("sim_dv_at_5", scan_dv, 1);
        chk("sim_scan_data", scan_data, 8'hA5);

        // Continuous scanner with a CPU write every 16 clks
        last_ack = -1; n_ack = 0; n_cpu = 0; n_dv = 0;
        sa = 10'h100;
        scan_addr = sa;
        scan_req = 1'b1;
        for (int c = 0; c < 66; c++) begin
            if (c % 16 == 0 && c < 64)
                cpu_strobe(1'b0, 10'(10'h200 + c / 16), 8'(8'h80 + c / 16));
            else
                cpu_cs = 1'b0;
            tick();
            obs_cycle(c);
        end
        cpu_cs = 1'b0;
        scan_req = 1'b0;
        for (int c = 66; c < 70; c++) begin
            tick();
            obs_cycle(c);
        end
        chk("cont_cpu_grants", n_cpu, 4);
        chk("cont_scan_acks_ge17", 32'(n_ack >= 17), 32'd1);
        chk("cont_dv_eq_ack", n_dv, n_ack);
        chk("cont_queue_empty", expq.size(), 0);
        for (int k = 0; k < 4; k++)
            chk("cont_cpu_wr_data", mem[11'(11'h600 + k)], 8'(8'h80 + k));

        // Two toggles while busy cancel
        cpu_strobe(1'b1, 10'h005, 8'h00);
        tick();
        cpu_cs = 1'b0;
        frame_tgl = 1'b1;
        tick(); tick();
        frame_tgl = 1'b0;
        tick(); tick();
        chk("dbl_tgl_frame", obj_frame, 1);

        // Reset during ACC of a CPU read
        cpu_strobe(1'b1, 10'h005, 8'h00);
        tick();
        cpu_cs = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_we", ram_we, 0);
        chk("rst_mid_rdata", cpu_rdata, 0);
        chk("rst_mid_frame", obj_frame, 0);
        tick(); tick();
        chk("rst_mid_rdata_held", cpu_rdata, 0);
        chk("rst_mid_no_dv", scan_dv, 0);

`ifdef JTROADF_OBJARB_STATS_EN
        chk("stats_zero", scan_wait_cnt, 0);
        cpu_strobe(1'b1, 10'h001, 8'h00);
        scan_req = 1'b1; scan_addr = 10'h001;
        tick();
        cpu_cs = 1'b0;
        chk("stats_1", scan_wait_cnt, 1);
        tick(); tick(); tick();
        chk("stats_ack", scan_ack, 1);
        chk("stats_4", scan_wait_cnt, 4);
        scan_req = 1'b0;
        tick(); tick();
        chk("stats_hold", scan_wait_cnt, 4);
        frame_tgl = 1'b1;
        tick();
        frame_tgl = 1'b0;
        chk("stats_clr_swap", scan_wait_cnt, 0);
        chk("stats_swap_frame", obj_frame, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtroadf_objram_arb.md
Name: jtroadf_objram_arb

Overview:
- Arbiter and bank controller for the double-buffered object RAM: one physical single-port 2×1 kB RAM shared by two requesters.
- Requester 1: main CPU, a bus strobe qualified by cpu_cen. Requester 2: object line scanner, a req/ack handshake.
- Owns obj_frame. The CPU always accesses bank obj_frame; the scanner always accesses bank ~obj_frame.
- Sits between the CPU decode (objram_cs, frame-toggle strobe) and the object video pipeline.

Parameters:
- AW, 10, address width of one bank; physical RAM address is AW+1 bits.
- DW, 8, data width.

Ports:
- clk  in  1  system clock, 24 MHz
- rst  in  1  synchronous reset, active-high
- cpu_cen  in  1  CPU bus clock enable; requests are sampled only when high
- cpu_cs  in  1  object RAM chip select from CPU decode
- cpu_rnw  in  1  1 = read, 0 = write
- cpu_addr  in  AW  CPU address within bank
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  last CPU read result, held until the next CPU read completes
- frame_tgl  in  1  one-clk pulse requesting a bank swap
- obj_frame  out  1  current CPU bank
- scan_req  in  1  scanner read request; held high until scan_ack
- scan_addr  in  AW  scanner address; stable while scan_req is high
- scan_ack  out  1  one-clk pulse when the scanner request is granted
- scan_data  out  DW  scanner read data
- scan_dv  out  1  one-clk pulse, scan_data valid
- ram_addr  out  AW+1  {bank, addr}, registered
- ram_we  out  1  write enable, registered
- ram_din  out  DW  write data, registered
- ram_dout  in  DW  RAM read data; 1 clk after ram_addr

Behaviour:
- Reset values: obj_frame=0, cpu_rdata=0, scan_data=0, scan_ack=0, scan_dv=0, ram_we=0, ram_addr=0, ram_din=0. Pending flags are cleared and the FSM is in IDLE.
- CPU capture: cpu_cs & cpu_cen sets cpu_pend and latches rnw, addr and wdata.
  - A new strobe while cpu_pend is already set overwrites the latched request (latest wins).
- FSM states: IDLE, ACC, LAT.
- IDLE, arbitration:
  - cpu_pend wins and moves the FSM to ACC. It drives ram_addr={obj_frame,addr}, ram_we=~rnw, ram_din=wdata, and clears cpu_pend.
  - Otherwise scan_req moves the FSM to ACC. It drives ram_addr={~obj_frame,scan_addr}, ram_we=0, and pulses scan_ack in this same clk.
  - Otherwise the FSM stays in IDLE.
- ACC: ram_we returns to 0 and the FSM moves to LAT.
- LAT: ram_dout is valid.
  - CPU read: cpu_rdata <= ram_dout.
  - Scanner read: scan_data <= ram_dout and scan_dv=1 for one clk.
  - CPU write: no data capture.
  - The FSM then returns to IDLE.
- Latency: the grant in IDLE is cycle 0 and data is registered at the end of LAT, so cpu_rdata/scan_dv update at cycle 2. One access per 3 clks maximum.
- Starvation: none. The CPU issues at most 1 access per 16 clks, so the scanner is guaranteed ≥4 of every 5 slots under continuous request.
- Bank swap:
  - frame_tgl XORs swap_pend, so two pulses before application cancel.
  - swap_pend is applied only in IDLE, before arbitration in the same clk: obj_frame <= ~obj_frame and swap_pend <= 0.
  - The arbitration in that clk uses the new obj_frame. An access already in flight completes on its original bank.
- Simultaneous frame_tgl and cpu strobe: both are captured. The swap precedes the CPU access.
- scan_req dropped before ack: the request is simply not served (protocol violation tolerated). A scan_req deassert/reassert is a new request.
- Reset mid-access: ram_we=0 on the next clk. No scan_dv and no cpu_rdata update is produced for the aborted access.

Optional Feature:
- Macro: JTROADF_OBJARB_STATS_EN.
- Defined: adds output scan_wait_cnt [15:0].
  - Counts clks with scan_req=1 and no scan_ack.
  - Saturates at 16'hFFFF and clears on rst and on each frame swap.
- Undefined: the port and counter are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package jtroadf_objarb_pkg: FSM state enum (IDLE/ACC/LAT), requester-select constants (SEL_CPU, SEL_SCAN), STATS_W=16.
- No sub-module needed. The optional stats counter may be the small sub-module jtroadf_objarb_stats.

Test Plan:
- After rst → obj_frame=0, ram_we=0. CPU write addr 0x05 data 0xA5 at cpu_cen → ram_addr=0x005 with ram_we=1 for exactly 1 clk, ram_din=0xA5. CPU read of the same address → cpu_rdata=0xA5 2 clks after grant.
- frame_tgl once → obj_frame=1 at next IDLE. Scanner read addr 0x005 → ram_addr=0x005 (bank 0), scan_dv with scan_data=0xA5. CPU write addr 0x005 → ram_addr=0x405.
- cpu strobe and scan_req in the same clk → CPU granted first. scan_ack arrives 3 clks later, its scan_dv 2 clks after that.
- Continuous scan_req for 64 clks with CPU strobes every 16 clks → no data loss. Scanner acks ≥17 and ack spacing ≥3 clks, with exactly 4 CPU grants.
- Two frame_tgl pulses 1 clk apart while FSM busy → obj_frame unchanged. rst asserted during ACC of a CPU read → cpu_rdata stays 0 and ram_we=0 the next clk.
- STATS_EN: hold scan_req while a CPU access is in progress → scan_wait_cnt increments once per unserved clk and clears on swap.
